// File: rtl/scan_chain_driver_if.sv
// ---------------------------------------------------------------------------
// scan_chain_driver_if
//  Bundles every non-clock, non-reset signal of scan_chain_driver.
//  Host side : Start, WrData/WrValid/WrReady, RdData/RdValid/RdReady,
//              Busy, Done, Err
//  Chain side: ScanOut (to datapath SDI), ScanIn (from datapath SDO), Test
//  Modports:
//   slave  - the scan chain driver itself
//   master - whatever drives the host bus and models the chain (e.g. a bench)
// ---------------------------------------------------------------------------
interface scan_chain_driver_if;
    logic        Start;
    logic [15:0] WrData;
    logic        WrValid;
    logic        WrReady;
    logic [15:0] RdData;
    logic        RdValid;
    logic        RdReady;
    logic        ScanOut;
    logic        ScanIn;
    logic        Test;
    logic        Busy;
    logic        Done;
    logic        Err;

    modport slave (
        input  Start, WrData, WrValid, RdReady, ScanIn,
        output WrReady, RdData, RdValid, ScanOut, Test, Busy, Done, Err
    );

    modport master (
        output Start, WrData, WrValid, RdReady, ScanIn,
        input  WrReady, RdData, RdValid, ScanOut, Test, Busy, Done, Err
    );
endinterface

// File: rtl/scan_chain_driver.sv
// ---------------------------------------------------------------------------
// scan_chain_driver
//  Tester-side driver for a datapath scan chain of CHAIN_LEN flops. The host
//  writes the chain image as 16-bit words (bit 0 shifted first); the block
//  shifts it in on consecutive clocks and hands back the unloaded chain
//  contents as 16-bit words (bit 0 captured first). Once shifting starts it
//  never pauses, so a late write word (underrun) or an unread capture word
//  (overrun) aborts the scan with the sticky Err flag.
//  Ports:
//   Clock  - system clock, all state on the rising edge
//   nReset - asynchronous active-low reset
//   bus    - scan_chain_driver_if.slave (host handshakes, chain pins, status)
//  Every output is taken straight from a flop.
// ---------------------------------------------------------------------------
module scan_chain_driver #(
    parameter int CHAIN_LEN = 64
) (
    input  logic                 Clock,
    input  logic                 nReset,
    scan_chain_driver_if.slave   bus
);

    localparam int WORDS = (CHAIN_LEN + 15) / 16;
    localparam int BL_W  = $clog2(CHAIN_LEN + 1);
    localparam int WF_W  = $clog2(WORDS + 1);

    localparam logic [BL_W-1:0] BL_INIT = BL_W'(CHAIN_LEN);
    localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);
    localparam logic [BL_W-1:0] BL_ZERO = BL_W'(0);
    localparam logic [WF_W-1:0] WF_INIT = WF_W'(WORDS);
    localparam logic [WF_W-1:0] WF_ONE  = WF_W'(1);
    localparam logic [WF_W-1:0] WF_ZERO = WF_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Registered state
    state_t            state_r;
    logic [15:0]       tx_shift_r;
    logic [15:0]       tx_buf_r;
    logic              tx_full_r;
    logic [15:0]       rx_shift_r;
    logic [15:0]       rd_data_r;
    logic              rd_valid_r;
    logic [3:0]        bit_cnt_r;
    logic [BL_W-1:0]   bits_left_r;
    logic [WF_W-1:0]   words_left_r;
    logic              err_r;
    logic              done_r;
    logic              test_r;
    logic              scan_out_r;
    logic              busy_r;
    logic              wr_ready_r;

    // Next-state values
    state_t            state_s;
    logic [15:0]       tx_shift_s;
    logic [15:0]       tx_buf_s;
    logic              tx_full_s;
    logic [15:0]       rx_shift_s;
    logic [15:0]       rd_data_s;
    logic              rd_valid_s;
    logic [3:0]        bit_cnt_s;
    logic [BL_W-1:0]   bits_left_s;
    logic [WF_W-1:0]   words_left_s;
    logic              err_s;
    logic              done_s;
    logic              test_s;
    logic              scan_out_s;
    logic              busy_s;
    logic              wr_ready_s;

    // Helpers
    logic              wr_xfer_s;
    logic              rd_xfer_s;
    logic              last_bit_s;
    logic              boundary_s;
    logic              overrun_s;
    logic              underrun_s;
    logic [15:0]       rx_bits_s;

    // Next-state and next-output logic for the whole block
    always_comb begin
        state_s      = state_r;
        tx_shift_s   = tx_shift_r;
        tx_buf_s     = tx_buf_r;
        tx_full_s    = tx_full_r;
        rx_shift_s   = rx_shift_r;
        rd_data_s    = rd_data_r;
        rd_valid_s   = rd_valid_r;
        bit_cnt_s    = bit_cnt_r;
        bits_left_s  = bits_left_r;
        words_left_s = words_left_r;
        err_s        = err_r;
        done_s       = 1'b0;

        wr_xfer_s    = bus.WrValid & wr_ready_r;
        rd_xfer_s    = rd_valid_r & bus.RdReady;
        last_bit_s   = (bits_left_r == BL_ONE);
        boundary_s   = (bit_cnt_r == 4'd15) || last_bit_s;
        // A read hand-off on the boundary edge frees rxBuf in time.
        overrun_s    = rd_valid_r & ~bus.RdReady;
        underrun_s   = ~last_bit_s & ~tx_full_r;
        rx_bits_s    = rx_shift_r;
        rx_bits_s[bit_cnt_r] = bus.ScanIn;

        // Host write into the one-word transmit buffer
        if (wr_xfer_s) begin
            tx_buf_s     = bus.WrData;
            tx_full_s    = 1'b1;
            words_left_s = words_left_r - WF_ONE;
        end else begin
            tx_buf_s     = tx_buf_r;
        end

        // Host read out of the receive buffer
        if (rd_xfer_s) begin
            rd_valid_s = 1'b0;
        end else begin
            rd_valid_s = rd_valid_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_s      = ST_PRIME;
                    err_s        = 1'b0;
                    bits_left_s  = BL_INIT;
                    words_left_s = WF_INIT;
                    bit_cnt_s    = 4'd0;
                    rx_shift_s   = 16'h0000;
                    tx_full_s    = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_PRIME: begin
                if (tx_full_r) begin
                    state_s    = ST_SHIFT;
                    tx_shift_s = tx_buf_r;
                    tx_full_s  = 1'b0;
                end else begin
                    state_s = ST_PRIME;
                end
            end

            ST_SHIFT: begin
                tx_shift_s  = {1'b0, tx_shift_r[15:1]};
                rx_shift_s  = rx_bits_s;
                bit_cnt_s   = bit_cnt_r + 4'd1;
                bits_left_s = bits_left_r - BL_ONE;
                if (boundary_s) begin
                    if (overrun_s || underrun_s) begin
                        // Abort: everything captured so far is thrown away.
                        state_s      = ST_IDLE;
                        err_s        = 1'b1;
                        rd_valid_s   = 1'b0;
                        rd_data_s    = 16'h0000;
                        tx_full_s    = 1'b0;
                        tx_shift_s   = 16'h0000;
                        rx_shift_s   = 16'h0000;
                        bit_cnt_s    = 4'd0;
                        bits_left_s  = BL_ZERO;
                        words_left_s = WF_ZERO;
                    end else begin
                        // rx_shift is cleared per word, so a short last word
                        // comes out zero-padded.
                        rd_data_s  = rx_bits_s;
                        rd_valid_s = 1'b1;
                        rx_shift_s = 16'h0000;
                        bit_cnt_s  = 4'd0;
                        if (!last_bit_s) begin
                            state_s    = ST_SHIFT;
                            tx_shift_s = tx_buf_r;
                            // A write landing on this edge refills the buffer.
                            tx_full_s  = wr_xfer_s;
                        end else begin
                            state_s = ST_DRAIN;
                        end
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end

            ST_DRAIN: begin
                if (rd_xfer_s) begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_DRAIN;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs are precomputed from the next state so they leave flops.
        test_s     = (state_s == ST_SHIFT);
        scan_out_s = test_s & tx_shift_s[0];
        busy_s     = (state_s != ST_IDLE);
        wr_ready_s = ~tx_full_s && (words_left_s != WF_ZERO) &&
                     ((state_s == ST_PRIME) || (state_s == ST_SHIFT));
    end

    // State and output registers; reset clears everything asynchronously
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_r      <= ST_IDLE;
            tx_shift_r   <= 16'h0000;
            tx_buf_r     <= 16'h0000;
            tx_full_r    <= 1'b0;
            rx_shift_r   <= 16'h0000;
            rd_data_r    <= 16'h0000;
            rd_valid_r   <= 1'b0;
            bit_cnt_r    <= 4'd0;
            bits_left_r  <= BL_ZERO;
            words_left_r <= WF_ZERO;
            err_r        <= 1'b0;
            done_r       <= 1'b0;
            test_r       <= 1'b0;
            scan_out_r   <= 1'b0;
            busy_r       <= 1'b0;
            wr_ready_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            tx_shift_r   <= tx_shift_s;
            tx_buf_r     <= tx_buf_s;
            tx_full_r    <= tx_full_s;
            rx_shift_r   <= rx_shift_s;
            rd_data_r    <= rd_data_s;
            rd_valid_r   <= rd_valid_s;
            bit_cnt_r    <= bit_cnt_s;
            bits_left_r  <= bits_left_s;
            words_left_r <= words_left_s;
            err_r        <= err_s;
            done_r       <= done_s;
            test_r       <= test_s;
            scan_out_r   <= scan_out_s;
            busy_r       <= busy_s;
            wr_ready_r   <= wr_ready_s;
        end
    end

    assign bus.WrReady = wr_ready_r;
    assign bus.RdData  = rd_data_r;
    assign bus.RdValid = rd_valid_r;
    assign bus.ScanOut = scan_out_r;
    assign bus.Test    = test_r;
    assign bus.Busy    = busy_r;
    assign bus.Done    = done_r;
    assign bus.Err     = err_r;

endmodule

// File: tb/tb_scan_chain_driver.sv
// ---------------------------------------------------------------------------
// tb_scan_chain_driver
//  Drives scan_chain_driver (CHAIN_LEN=40, three words, short last word)
//  against a loopback chain model. Each scan's expectations come from the
//  chain rules: the words read back are the preloaded chain image, the chain
//  ends up holding the written image, Test is high for CHAIN_LEN cycles, and
//  an abort happens at the boundary whose data was missing or unread.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_scan_chain_driver;

    localparam int L  = 40;
    localparam int NW = (L + 15) / 16;

    logic Clock = 1'b0;
    logic nReset;
    int   n_vec = 0;
    int   n_bad = 0;

    // Free-running clock
    always #5 Clock = ~Clock;

    scan_chain_driver_if ifc ();

    scan_chain_driver #(.CHAIN_LEN(L)) dut (
        .Clock  (Clock),
        .nReset (nReset),
        .bus    (ifc)
    );

    // Loopback chain: SDO is bit 0, SDI enters at the top on every Test clock
    logic [L-1:0] chain_r;
    logic [L-1:0] preload;
    logic         load_req;
    always @(posedge Clock) begin
        if (load_req) chain_r <= preload;
        else if (ifc.Test) chain_r <= {ifc.ScanOut, chain_r[L-1:1]};
    end
    assign ifc.ScanIn = chain_r[0];

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 clean, 1 underrun, 2 overrun, 3 read hand-off on boundary, 4 reset mid-shift
    task automatic run_scan(input int mode, input bit fixed);
        logic [15:0]       wimg [NW];
        logic [16*NW-1:0]  wflat;
        logic [16*NW-1:0]  pflat;
        logic [15:0]       got [$];
        int wi, test_cnt, done_early, cyc, rd_wait, dly;
        bit finished;

        wflat = '0;
        pflat = '0;
        for (int j = 0; j < NW; j++) begin
            wimg[j] = 16'($urandom);
        end
        pflat[L-1:0] = L'({$urandom, $urandom});
        if (fixed) begin
            wimg[0] = 16'h1111; wimg[1] = 16'h2222; wimg[2] = 16'h0033;
            pflat[L-1:0] = L'(48'h00CC_BBBB_AAAA);
        end
        for (int j = 0; j < NW; j++) wflat[16*j +: 16] = wimg[j];

        preload = pflat[L-1:0];
        @(negedge Clock); load_req = 1'b1;
        @(negedge Clock); load_req = 1'b0;
        ifc.Start = 1'b1;
        @(negedge Clock);
        ifc.Start = 1'b0;
        check_value("err_clear_on_start", ifc.Err, 1'b0);
        check_value("busy_after_start", ifc.Busy, 1'b1);

        wi = 0; test_cnt = 0; done_early = 0; cyc = 0; rd_wait = 0;
        dly = $urandom_range(0, 4);
        finished = 1'b0;
        while (!finished && cyc < 400) begin
            if (ifc.Test) test_cnt++;
            if (ifc.Done) done_early++;

            if (mode == 4 && test_cnt == 8) begin
                nReset = 1'b0;
                #1;
                check_value("rst_test", ifc.Test, 1'b0);
                check_value("rst_scanout", ifc.ScanOut, 1'b0);
                check_value("rst_rdvalid", ifc.RdValid, 1'b0);
                check_value("rst_busy", ifc.Busy, 1'b0);
                ifc.WrValid = 1'b0; ifc.RdReady = 1'b0; ifc.Start = 1'b0;
                @(negedge Clock);
                nReset = 1'b1;
                finished = 1'b1;
                break;
            end

            ifc.WrValid = (wi < NW) && (cyc >= dly) && !(mode == 1 && wi >= 1);
            ifc.WrData  = (wi < NW) ? wimg[wi] : 16'h0000;

            if (mode == 2) ifc.RdReady = 1'b0;
            else if (mode == 3 && test_cnt < 32) ifc.RdReady = 1'b0;
            else if (mode == 3 && test_cnt == 32) begin
                ifc.RdReady = 1'b1;
                check_value("handoff_pending", ifc.RdValid, 1'b1);
            end
            else ifc.RdReady = ($urandom_range(0, 1) == 1) || (rd_wait >= 5);

            ifc.Start = (mode == 0) && ifc.Busy && ($urandom_range(0, 7) == 0);

            if (ifc.WrValid && ifc.WrReady) wi++;
            if (ifc.RdValid && ifc.RdReady) begin
                got.push_back(ifc.RdData);
                rd_wait = 0;
            end else if (ifc.RdValid) begin
                rd_wait++;
            end

            @(negedge Clock);
            cyc++;
            if (!ifc.Busy) finished = 1'b1;
        end
        ifc.WrValid = 1'b0; ifc.RdReady = 1'b0; ifc.Start = 1'b0;
        check_value("scan_terminates", finished, 1'b1);

        if (mode == 0 || mode == 3) begin
            check_value("done_pulse", ifc.Done, 1'b1);
            check_value("no_early_done", done_early, 0);
            check_value("err_clean", ifc.Err, 1'b0);
            check_value("test_cycles", test_cnt, L);
            check_value("read_count", got.size(), NW);
            for (int j = 0; j < NW; j++) begin
                if (j < got.size()) check_value("read_word", got[j], pflat[16*j +: 16]);
            end
            check_value("chain_image", chain_r, wflat[L-1:0]);
            @(negedge Clock);
            check_value("done_one_cycle", ifc.Done, 1'b0);
        end else if (mode == 1) begin
            check_value("underrun_err", ifc.Err, 1'b1);
            check_value("underrun_no_done", ifc.Done, 1'b0);
            check_value("underrun_test_cycles", test_cnt, 16);
            check_value("underrun_test_low", ifc.Test, 1'b0);
            check_value("underrun_rdvalid", ifc.RdValid, 1'b0);
        end else if (mode == 2) begin
            check_value("overrun_err", ifc.Err, 1'b1);
            check_value("overrun_no_done", ifc.Done, 1'b0);
            check_value("overrun_test_cycles", test_cnt, 32);
            check_value("overrun_rdvalid", ifc.RdValid, 1'b0);
            check_value("overrun_reads", got.size(), 0);
        end else begin
            check_value("post_rst_busy", ifc.Busy, 1'b0);
            check_value("post_rst_err", ifc.Err, 1'b0);
        end
        @(negedge Clock);
    endtask

    // Bounded run time
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Main sequence
    initial begin
        nReset = 1'b0;
        load_req = 1'b0;
        preload = '0;
        ifc.Start = 1'b0; ifc.WrValid = 1'b0; ifc.WrData = 16'h0000; ifc.RdReady = 1'b0;
        repeat (3) @(negedge Clock);
        check_value("reset_test", ifc.Test, 1'b0);
        check_value("reset_scanout", ifc.ScanOut, 1'b0);
        check_value("reset_busy", ifc.Busy, 1'b0);
        check_value("reset_done", ifc.Done, 1'b0);
        check_value("reset_err", ifc.Err, 1'b0);
        check_value("reset_rdvalid", ifc.RdValid, 1'b0);
        check_value("reset_wrready", ifc.WrReady, 1'b0);
        check_value("reset_rddata", ifc.RdData, 16'h0000);
        nReset = 1'b1;
        @(negedge Clock);

        run_scan(0, 1'b1);
        run_scan(1, 1'b0);
        run_scan(0, 1'b0);
        run_scan(2, 1'b0);
        run_scan(3, 1'b0);
        run_scan(4, 1'b0);
        run_scan(0, 1'b0);
        for (int k = 0; k < 8; k++) run_scan(0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
